// File: rtl/delay_timer_bank.sv
// Bank of NCH independent programmable delay/period timers with shadowed period registers.
// Define DELAY_TIMER_BANK_ONESHOT_EN to honour `mode` (one-shot channels park in DONE).
module delay_timer_bank #(
  parameter int NCH            = 4,
  parameter int CBITS          = 11,
  parameter int DEFAULT_PERIOD = 1250,
  localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   flg,
  output logic [NCH-1:0]   done,
  output logic             err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef DELAY_TIMER_BANK_ONESHOT_EN
  localparam logic [1:0] ST_DONE = 2'd2;
`endif

  localparam logic [CBITS-1:0] PERIOD_RST = CBITS'(DEFAULT_PERIOD);
  localparam logic [CBITS-1:0] CNT_ONE    = CBITS'(1);

  logic [1:0]       st_q  [NCH];
  logic [1:0]       st_d  [NCH];
  logic [CBITS-1:0] cnt_q [NCH];
  logic [CBITS-1:0] cnt_d [NCH];
  logic [CBITS-1:0] s_q   [NCH];
  logic [CBITS-1:0] s_d   [NCH];
  logic [CBITS-1:0] a_q   [NCH];
  logic [CBITS-1:0] a_d   [NCH];
  logic [NCH-1:0]   sig_q, sig_d;
  logic [NCH-1:0]   flg_q, flg_d;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   over;
  logic             err_q, err_d;

  always_comb begin
    sig_d = '0;
    flg_d = '0;
    wr_hit = '0;
    over = '0;
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      a_d[i]   = a_q[i];
      s_d[i]   = s_q[i];
      // Out-of-range channel numbers match no i, so such writes fall away.
      wr_hit[i] = cfg_we && (int'(cfg_ch) == i);
      if (wr_hit[i]) s_d[i] = cfg_period;
      over[i] = (st_q[i] == ST_RUN) && (cnt_q[i] > a_q[i]);

      case (st_q[i])
        ST_IDLE: begin
          cnt_d[i] = '0;
          if (en[i]) begin
            st_d[i] = ST_RUN;
            a_d[i]  = s_q[i];
          end
        end
        ST_RUN: begin
          if (!en[i]) begin
            // Abort beats expiry: no pulse when en drops on the terminal count.
            st_d[i]  = ST_IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == a_q[i]) begin
            sig_d[i] = 1'b1;
            cnt_d[i] = '0;
`ifdef DELAY_TIMER_BANK_ONESHOT_EN
            if (mode[i]) st_d[i] = ST_DONE;
            else         a_d[i]  = s_d[i];
`else
            a_d[i] = s_d[i];
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
`ifdef DELAY_TIMER_BANK_ONESHOT_EN
        ST_DONE: begin
          cnt_d[i] = '0;
          if (!en[i]) st_d[i] = ST_IDLE;
        end
`endif
        default: begin
          st_d[i]  = ST_IDLE;
          cnt_d[i] = '0;
        end
      endcase

      flg_d[i] = (st_d[i] == ST_RUN);
    end
    err_d = err_q | (|over);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
        s_q[i]   <= PERIOD_RST;
        a_q[i]   <= PERIOD_RST;
      end
      sig_q <= '0;
      flg_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        s_q[i]   <= s_d[i];
        a_q[i]   <= a_d[i];
      end
      sig_q <= sig_d;
      flg_q <= flg_d;
      err_q <= err_d;
    end
  end

`ifdef DELAY_TIMER_BANK_ONESHOT_EN
  logic [NCH-1:0] done_q, done_d;

  always_comb begin
    done_d = '0;
    for (int i = 0; i < NCH; i++) done_d[i] = (st_d[i] == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) done_q <= '0;
    else     done_q <= done_d;
  end

  assign done = done_q;
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign done = '0;
`endif

  assign sig = sig_q;
  assign flg = flg_q;
  assign err = err_q;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed and randomised checks of delay_timer_bank with NCH=4, CBITS=4, DEFAULT_PERIOD=5.
// One-shot checks follow DELAY_TIMER_BANK_ONESHOT_EN.
module tb_delay_timer_bank;
  localparam int NCH = 4;
  localparam int CBITS = 4;
  localparam int DP = 5;
`ifdef DELAY_TIMER_BANK_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] en, mode;
  logic cfg_we;
  logic [1:0] cfg_ch;
  logic [CBITS-1:0] cfg_period;
  logic [NCH-1:0] sig, flg, done;
  logic err;

  int n_checks = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  int m_st[NCH];
  int m_cnt[NCH];
  int m_a[NCH];
  int m_s[NCH];

  delay_timer_bank #(.NCH(NCH), .CBITS(CBITS), .DEFAULT_PERIOD(DP)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .sig(sig), .flg(flg), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_period(input int ch, input int p);
    cfg_we = 1'b1;
    cfg_ch = ch[1:0];
    cfg_period = p[CBITS-1:0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; mode = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
    tick(); tick();
    n_checks++; if (sig !== 4'h0) begin n_fail++; $display("FAIL reset_sig: got %h expected 0", sig); end
    n_checks++; if (flg !== 4'h0) begin n_fail++; $display("FAIL reset_flg: got %h expected 0", flg); end
    n_checks++; if (done !== 4'h0) begin n_fail++; $display("FAIL reset_done: got %h expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    tick();
    n_checks++; if (flg !== 4'h0) begin n_fail++; $display("FAIL idle_flg: got %h expected 0", flg); end
  endtask

  task automatic test_periodic();
    logic e;
    en[0] = 1'b1;
    tick();
    n_checks++; if (flg[0] !== 1'b1) begin n_fail++; $display("FAIL per_start_flg: got %b expected 1", flg[0]); end
    n_checks++; if (sig[0] !== 1'b0) begin n_fail++; $display("FAIL per_start_sig: got %b expected 0", sig[0]); end
    for (int k = 1; k <= 18; k++) begin
      tick();
      e = (k % 6 == 0);
      n_checks++; if (sig[0] !== e) begin n_fail++; $display("FAIL per_sig k=%0d: got %b expected %b", k, sig[0], e); end
    end
    en[0] = 1'b0;
    tick();
    n_checks++; if (flg[0] !== 1'b0) begin n_fail++; $display("FAIL per_stop_flg: got %b expected 0", flg[0]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL per_err: got %b expected 0", err); end
  endtask

  task automatic test_period_update();
    logic e;
    write_period(1, 2);
    en[1] = 1'b1;
    tick();
    for (int k = 1; k <= 26; k++) begin
      if (k == 4) begin cfg_we = 1'b1; cfg_ch = 2'd1; cfg_period = 4'd9; end
      tick();
      cfg_we = 1'b0;
      e = (k == 3 || k == 6 || k == 16 || k == 26);
      n_checks++; if (sig[1] !== e) begin n_fail++; $display("FAIL upd_sig k=%0d: got %b expected %b", k, sig[1], e); end
    end
    en[1] = 1'b0;
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL upd_err: got %b expected 0", err); end
  endtask

  task automatic test_zero_period();
    write_period(2, 0);
    en[2] = 1'b1;
    tick();
    n_checks++; if (sig[2] !== 1'b0) begin n_fail++; $display("FAIL zero_first_sig: got %b expected 0", sig[2]); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++; if (sig[2] !== 1'b1) begin n_fail++; $display("FAIL zero_sig k=%0d: got %b expected 1", k, sig[2]); end
    end
    en[2] = 1'b0;
    tick();
    n_checks++; if (sig[2] !== 1'b0) begin n_fail++; $display("FAIL zero_stop_sig: got %b expected 0", sig[2]); end
    n_checks++; if (flg[2] !== 1'b0) begin n_fail++; $display("FAIL zero_stop_flg: got %b expected 0", flg[2]); end
  endtask

  task automatic test_oneshot();
    logic e;
    write_period(3, 3);
    mode[3] = 1'b1;
    en[3] = 1'b1;
    tick();
    n_checks++; if (flg[3] !== 1'b1) begin n_fail++; $display("FAIL os_start_flg: got %b expected 1", flg[3]); end
`ifdef DELAY_TIMER_BANK_ONESHOT_EN
    for (int k = 1; k <= 7; k++) begin
      tick();
      e = (k == 4);
      n_checks++; if (sig[3] !== e) begin n_fail++; $display("FAIL os_sig k=%0d: got %b expected %b", k, sig[3], e); end
      n_checks++; if (done[3] !== (k >= 4)) begin n_fail++; $display("FAIL os_done k=%0d: got %b expected %b", k, done[3], k >= 4); end
      n_checks++; if (flg[3] !== (k < 4)) begin n_fail++; $display("FAIL os_flg k=%0d: got %b expected %b", k, flg[3], k < 4); end
    end
    en[3] = 1'b0;
    tick();
    n_checks++; if (done[3] !== 1'b0) begin n_fail++; $display("FAIL os_idle_done: got %b expected 0", done[3]); end
    en[3] = 1'b1;
    tick();
    n_checks++; if (flg[3] !== 1'b1) begin n_fail++; $display("FAIL os_rearm_flg: got %b expected 1", flg[3]); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = (k == 4);
      n_checks++; if (sig[3] !== e) begin n_fail++; $display("FAIL os_rearm_sig k=%0d: got %b expected %b", k, sig[3], e); end
    end
    n_checks++; if (done[3] !== 1'b1) begin n_fail++; $display("FAIL os_rearm_done: got %b expected 1", done[3]); end
`else
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k == 4 || k == 8);
      n_checks++; if (sig[3] !== e) begin n_fail++; $display("FAIL os_off_sig k=%0d: got %b expected %b", k, sig[3], e); end
      n_checks++; if (done[3] !== 1'b0) begin n_fail++; $display("FAIL os_off_done k=%0d: got %b expected 0", k, done[3]); end
      n_checks++; if (flg[3] !== 1'b1) begin n_fail++; $display("FAIL os_off_flg k=%0d: got %b expected 1", k, flg[3]); end
    end
`endif
    en[3] = 1'b0;
    mode[3] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    logic [3:0] e;
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++; if (sig[0] !== 1'b0) begin n_fail++; $display("FAIL abort_pre_sig k=%0d: got %b expected 0", k, sig[0]); end
    end
    en[0] = 1'b0;
    tick();
    n_checks++; if (sig[0] !== 1'b0) begin n_fail++; $display("FAIL abort_sig: got %b expected 0", sig[0]); end
    n_checks++; if (flg[0] !== 1'b0) begin n_fail++; $display("FAIL abort_flg: got %b expected 0", flg[0]); end
    en[0] = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++; if (sig[0] !== (k == 6)) begin n_fail++; $display("FAIL abort_restart_sig k=%0d: got %b expected %b", k, sig[0], k == 6); end
    end
    en = 4'hf;
    tick(); tick(); tick();
    rst = 1'b1;
    en = 4'h0;
    tick();
    n_checks++; if (sig !== 4'h0) begin n_fail++; $display("FAIL rst_mid_sig: got %h expected 0", sig); end
    n_checks++; if (flg !== 4'h0) begin n_fail++; $display("FAIL rst_mid_flg: got %h expected 0", flg); end
    n_checks++; if (done !== 4'h0) begin n_fail++; $display("FAIL rst_mid_done: got %h expected 0", done); end
    rst = 1'b0;
    en = 4'hf;
    tick();
    n_checks++; if (flg !== 4'hf) begin n_fail++; $display("FAIL rst_restart_flg: got %h expected f", flg); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = (k == 6) ? 4'hf : 4'h0;
      n_checks++; if (sig !== e) begin n_fail++; $display("FAIL rst_default_sig k=%0d: got %h expected %h", k, sig, e); end
    end
    en = 4'h0;
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b expected 0", err); end
  endtask

  task automatic test_random();
    logic [3:0] e_sig, e_flg, e_done;
    logic [11:0] exp_v;
    int sn;
    rst = 1'b1; en = '0; mode = '0; cfg_we = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_a[c] = DP; m_s[c] = DP;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 11) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 19) == 0) mode[c] = ~mode[c];
      end
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_period = 4'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) begin
        sn = (cfg_we && cfg_ch == c) ? int'(cfg_period) : m_s[c];
        e_sig[c] = 1'b0;
        case (m_st[c])
          0: if (en[c]) begin m_st[c] = 1; m_cnt[c] = 0; m_a[c] = m_s[c]; end
          1: begin
            if (!en[c]) begin
              m_st[c] = 0; m_cnt[c] = 0;
            end else if (m_cnt[c] == m_a[c]) begin
              e_sig[c] = 1'b1; m_cnt[c] = 0;
              if (ONESHOT && mode[c]) m_st[c] = 2;
              else m_a[c] = sn;
            end else begin
              m_cnt[c]++;
            end
          end
          default: if (!en[c]) m_st[c] = 0;
        endcase
        m_s[c] = sn;
        e_flg[c] = (m_st[c] == 1);
        e_done[c] = (m_st[c] == 2);
      end
      exp_q.push_back({e_sig, e_flg, e_done});
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if ({sig, flg, done} !== exp_v) begin n_fail++; $display("FAIL rand_outputs cyc=%0d: got %h expected %h", cyc, {sig, flg, done}, exp_v); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err cyc=%0d: got %b expected 0", cyc, err); end
    end
    en = '0;
    cfg_we = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_period_update();
    test_zero_period();
    test_oneshot();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
